execute_stage: RTL

- EX pipeline stage of the MIPS core. Sits between the ID/EX operand latch and the memory_access stage.
- Computes the ALU result and forwards store data, memory control, write-back control and PC into the EX/MEM register that feeds memory access.
- Contains an iterative 32-cycle multiply/divide unit that owns the HI/LO registers. It raises a stall for dependent instructions while busy.

---
 rtl/mips_ex_pkg.sv | 46 ++++
 rtl/mul_div_unit.sv | 129 ++++++++++++
 rtl/execute_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_ex_pkg.sv
// Shared definitions for the MIPS execute stage: ALU opcodes, mul/div FSM states
// and the fixed results returned for a divide by zero.
package mips_ex_pkg;

    localparam int NB_ALU_OP = 5;

    localparam logic [NB_ALU_OP-1:0] ALU_ADD   = 5'd0;
    localparam logic [NB_ALU_OP-1:0] ALU_SUB   = 5'd1;
    localparam logic [NB_ALU_OP-1:0] ALU_AND   = 5'd2;
    localparam logic [NB_ALU_OP-1:0] ALU_OR    = 5'd3;
    localparam logic [NB_ALU_OP-1:0] ALU_XOR   = 5'd4;
    localparam logic [NB_ALU_OP-1:0] ALU_NOR   = 5'd5;
    localparam logic [NB_ALU_OP-1:0] ALU_SLT   = 5'd6;
    localparam logic [NB_ALU_OP-1:0] ALU_SLTU  = 5'd7;
    localparam logic [NB_ALU_OP-1:0] ALU_SLL   = 5'd8;
    localparam logic [NB_ALU_OP-1:0] ALU_SRL   = 5'd9;
    localparam logic [NB_ALU_OP-1:0] ALU_SRA   = 5'd10;
    localparam logic [NB_ALU_OP-1:0] ALU_SLLV  = 5'd11;
    localparam logic [NB_ALU_OP-1:0] ALU_SRLV  = 5'd12;
    localparam logic [NB_ALU_OP-1:0] ALU_SRAV  = 5'd13;
    localparam logic [NB_ALU_OP-1:0] ALU_LUI   = 5'd14;
    localparam logic [NB_ALU_OP-1:0] ALU_MFHI  = 5'd15;
    localparam logic [NB_ALU_OP-1:0] ALU_MFLO  = 5'd16;
    localparam logic [NB_ALU_OP-1:0] ALU_MULT  = 5'd17;
    localparam logic [NB_ALU_OP-1:0] ALU_MULTU = 5'd18;
    localparam logic [NB_ALU_OP-1:0] ALU_DIV   = 5'd19;
    localparam logic [NB_ALU_OP-1:0] ALU_DIVU  = 5'd20;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // Divide by zero returns an all-ones quotient; HI gets the raw dividend.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic is_md_op(input logic [NB_ALU_OP-1:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_hilo_dep(input logic [NB_ALU_OP-1:0] op);
        return is_md_op(op) || (op == ALU_MFHI) || (op == ALU_MFLO);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider that owns HI and LO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | waiting for a mul/div; HI/LO hold the last result
//   MD_RUN  | one partial product or quotient bit per advancing cycle
//   MD_FIX  | apply result signs, write HI/LO
module mul_div_unit
    import mips_ex_pkg::*;
#(
    parameter int NB_REG = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_ALU_OP-1:0] i_op,
    input  logic [NB_REG-1:0]    i_a,
    input  logic [NB_REG-1:0]    i_b,
    input  logic                 i_advance,
    output logic [NB_REG-1:0]    o_hi,
    output logic [NB_REG-1:0]    o_lo,
    output logic                 o_busy
);

    localparam int NB_CNT = $clog2(NB_REG);

    md_state_t           state, state_next;
    logic                load, step, fix;
    logic [NB_CNT-1:0]   cnt;
    logic                is_div, neg_res, neg_rem, div_zero;
    logic [NB_REG-1:0]   md_op, acc_hi, acc_lo;

    logic                op_signed, op_div;
    logic [NB_REG-1:0]   mag_a, mag_b;
    logic [NB_REG:0]     mul_sum;
    logic [NB_REG:0]     div_shift;
    logic                div_ge;
    logic [NB_REG-1:0]   div_sub;
    logic [2*NB_REG-1:0] prod_fix;

    assign op_signed = (i_op == ALU_MULT) || (i_op == ALU_DIV);
    assign op_div    = (i_op == ALU_DIV) || (i_op == ALU_DIVU);
    assign mag_a     = (op_signed && i_a[NB_REG-1]) ? -i_a : i_a;
    assign mag_b     = (op_signed && i_b[NB_REG-1]) ? -i_b : i_b;

    // Multiply: {acc_hi, acc_lo} starts as {0, multiplier} and shifts right.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_op} : '0);
    // Divide: {acc_hi, acc_lo} starts as {0, dividend} and shifts left.
    assign div_shift = {acc_hi, acc_lo[NB_REG-1]};
    assign div_ge    = div_shift >= {1'b0, md_op};
    assign div_sub   = div_shift[NB_REG-1:0] - md_op;
    assign prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state  <= MD_IDLE;
            o_busy <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next != MD_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state)
            MD_IDLE: if (i_advance && i_start) begin
                load       = 1'b1;
                state_next = MD_RUN;
            end
            MD_RUN: if (i_advance) begin
                step = 1'b1;
                if (cnt == '0) state_next = MD_FIX;
            end
            MD_FIX: if (i_advance) begin
                fix        = 1'b1;
                state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            md_op    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            o_hi     <= '0;
            o_lo     <= '0;
        end else if (load) begin
            cnt      <= NB_CNT'(NB_REG - 1);
            is_div   <= op_div;
            neg_res  <= op_signed && (i_a[NB_REG-1] ^ i_b[NB_REG-1]);
            neg_rem  <= op_signed && i_a[NB_REG-1];
            div_zero <= (i_b == '0);
            md_op    <= op_div ? mag_b : mag_a;
            acc_hi   <= '0;
            acc_lo   <= op_div ? mag_a : mag_b;
        end else if (step) begin
            cnt <= cnt - NB_CNT'(1);
            if (is_div) begin
                acc_hi <= div_ge ? div_sub : div_shift[NB_REG-1:0];
                acc_lo <= {acc_lo[NB_REG-2:0], div_ge};
            end else begin
                acc_hi <= mul_sum[NB_REG:1];
                acc_lo <= {mul_sum[0], acc_lo[NB_REG-1:1]};
            end
        end else if (fix) begin
            if (is_div) begin
                // With a zero divisor every trial subtract succeeds, so acc_hi
                // ends up holding |dividend| and the sign fix restores it raw.
                o_lo <= div_zero ? DIV0_LO[NB_REG-1:0] : (neg_res ? -acc_lo : acc_lo);
                o_hi <= neg_rem ? -acc_hi : acc_hi;
            end else begin
                o_hi <= prod_fix[2*NB_REG-1:NB_REG];
                o_lo <= prod_fix[NB_REG-1:0];
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ALU, HI/LO hazard stall and the EX/MEM pipeline register,
// with the iterative mul/div unit alongside.
module execute_stage
    import mips_ex_pkg::*;
#(
    parameter int NB_REG = 32,
    parameter int NB_EX  = 6,
    parameter int NB_MEM = 5,
    parameter int NB_WB  = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [NB_REG-1:0] i_a,
    input  logic [NB_REG-1:0] i_b,
    input  logic [NB_REG-1:0] i_imm,
    input  logic [4:0]        i_shamt,
    input  logic [NB_EX-1:0]  i_ex,
    input  logic [NB_MEM-1:0] i_mem,
    input  logic [NB_WB-1:0]  i_wb,
    input  logic [NB_REG-1:0] i_pc,
    output logic [NB_REG-1:0] o_alu_o,
    output logic [NB_REG-1:0] o_b_o,
    output logic [NB_MEM-1:0] o_mem,
    output logic [NB_WB-1:0]  o_wb,
    output logic [NB_REG-1:0] o_pc,
    output logic              o_stall,
    output logic              o_busy
);

    logic                 alu_src;
    logic [NB_ALU_OP-1:0] alu_op;
    logic [NB_REG-1:0]    op_b, alu_res, hi, lo;
    logic                 md_start;

    assign alu_src  = i_ex[NB_EX-1];
    assign alu_op   = i_ex[NB_ALU_OP-1:0];
    assign op_b     = alu_src ? i_imm : i_b;
    assign o_stall  = o_busy && is_hilo_dep(alu_op);
    assign md_start = is_md_op(alu_op) && !o_stall;

    mul_div_unit #(
        .NB_REG (NB_REG)
    ) u_mul_div (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_start   (md_start),
        .i_op      (alu_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_advance (i_valid),
        .o_hi      (hi),
        .o_lo      (lo),
        .o_busy    (o_busy)
    );

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = i_a + op_b;
            ALU_SUB:  alu_res = i_a - op_b;
            ALU_AND:  alu_res = i_a & op_b;
            ALU_OR:   alu_res = i_a | op_b;
            ALU_XOR:  alu_res = i_a ^ op_b;
            ALU_NOR:  alu_res = ~(i_a | op_b);
            ALU_SLT:  alu_res = {{(NB_REG-1){1'b0}}, $signed(i_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(NB_REG-1){1'b0}}, i_a < op_b};
            ALU_SLL:  alu_res = op_b << i_shamt;
            ALU_SRL:  alu_res = op_b >> i_shamt;
            ALU_SRA:  alu_res = $signed(op_b) >>> i_shamt;
            ALU_SLLV: alu_res = op_b << i_a[4:0];
            ALU_SRLV: alu_res = op_b >> i_a[4:0];
            ALU_SRAV: alu_res = $signed(op_b) >>> i_a[4:0];
            ALU_LUI:  alu_res = {op_b[15:0], {(NB_REG-16){1'b0}}};
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // A stalled instruction leaves a bubble behind rather than a duplicate.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_alu_o <= '0;
            o_b_o   <= '0;
            o_mem   <= '0;
            o_wb    <= '0;
            o_pc    <= '0;
        end else if (i_valid) begin
            if (o_stall) begin
                o_alu_o <= '0;
                o_b_o   <= '0;
                o_mem   <= '0;
                o_wb    <= '0;
                o_pc    <= '0;
            end else begin
                o_alu_o <= alu_res;
                o_b_o   <= i_b;
                o_mem   <= i_mem;
                o_wb    <= i_wb;
                o_pc    <= i_pc;
            end
        end
    end

endmodule
